mic_pdm_core: RTL and testbench

MMIO slot core that drives the on-board PDM microphone and turns its 1-bit stream into PCM samples.
- Generates mic_clk and samples mic_data.
- Decimates by counting ones over a fixed window of PDM bits.
- Buffers the resulting samples in a FIFO.
- Plugs into mmio_sys_vanilla as one FPro slot, between the top-level mic pins and the bridge/MCS read path.

---
 rtl/mic_pdm_core.sv | 186 ++++++++++++++++++
 tb/tb_mic_pdm_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_pdm_core.sv
// PDM microphone slot: mic clock generation, 2-flop input sync,
// ones-count decimation and a sample FIFO behind a 4-word register map.
module mic_pdm_core #(
  parameter int CLK_DIV = 20,
  parameter int DECIM   = 128,
  parameter int FIFO_AW = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        mic_clk,
  input  logic        mic_data,
  output logic        mic_lrsel
);

  localparam int W     = $clog2(DECIM + 1);
  localparam int DW    = $clog2(CLK_DIV + 1);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [W-1:0]  BIT_LAST = W'(DECIM - 1);

  logic          en;
  logic          clk_q;
  logic [DW-1:0] div;
  logic          sync1;
  logic          sync2;
  logic [W-1:0]  bit_cnt;
  logic [W-1:0]  ones_cnt;

  logic               ovf;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic [W-1:0]       mem [DEPTH];

  logic         sel_w;
  logic         pop_req;
  logic         ctl_wr;
  logic         clr_fifo;
  logic         clr_ovf;
  logic         wrap;
  logic         capture;
  logic         push;
  logic [W-1:0] sample;
  logic         empty;
  logic         full;
  logic         do_pop;
  logic         do_push;
  logic         ovf_evt;
  logic [W-1:0] head;
  logic         unused;

  assign unused    = &{1'b0, read, addr[4:2], wr_data[31:3]};
  assign mic_lrsel = 1'b0;
  assign mic_clk   = clk_q;

  assign sel_w    = cs & write;
  assign pop_req  = sel_w & (addr[1:0] == 2'd2);
  assign ctl_wr   = sel_w & (addr[1:0] == 2'd3);
  assign clr_fifo = ctl_wr & wr_data[1];
  assign clr_ovf  = ctl_wr & wr_data[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en <= 1'b0;
    end else if (ctl_wr) begin
      en <= wr_data[0];
    end
  end

  // Falling mic_clk toggle is the capture point for one PDM bit.
  assign wrap    = en && (div == DIV_LAST);
  assign capture = wrap && clk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= '0;
      clk_q <= 1'b0;
    end else if (!en) begin
      div   <= '0;
      clk_q <= 1'b0;
    end else if (wrap) begin
      div   <= '0;
      clk_q <= ~clk_q;
    end else begin
      div   <= div + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= mic_data;
      sync2 <= sync1;
    end
  end

  assign push   = capture && (bit_cnt == BIT_LAST);
  assign sample = ones_cnt + W'(sync2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (!en) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (capture) begin
      if (bit_cnt == BIT_LAST) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
      end else begin
        bit_cnt  <= bit_cnt + W'(1);
        ones_cnt <= sample;
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop_req & ~empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push & (~full | do_pop);
  assign ovf_evt = push & full & ~do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_fifo) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (ovf_evt) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

  always_comb begin
    rd_data = '0;
    unique case (addr[1:0])
      2'd0: rd_data[W-1:0] = head;
      2'd1: begin
        rd_data[0]            = empty;
        rd_data[1]            = full;
        rd_data[2]            = ovf;
        rd_data[3]            = en;
        rd_data[8+FIFO_AW:8]  = count;
      end
      default: rd_data[0] = en;
    endcase
  end

endmodule

// File: tb/tb_mic_pdm_core.sv
// Bench for mic_pdm_core: acts as the microphone and checks samples,
// status and FIFO behaviour against a queue-based reference.
module tb_mic_pdm_core;

  localparam int CLK_DIV = 4;
  localparam int DECIM   = 16;
  localparam int FIFO_AW = 4;
  localparam int DEPTH   = 2 ** FIFO_AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        mic_clk;
  logic        mic_data = 1'b0;
  logic        mic_lrsel;

  int ncmp = 0;
  int nfail = 0;

  int q[$];
  bit m_en = 0;
  bit m_ovf = 0;
  int m_bits = 0;
  int m_ones = 0;

  mic_pdm_core #(
    .CLK_DIV(CLK_DIV),
    .DECIM  (DECIM),
    .FIFO_AW(FIFO_AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .mic_clk  (mic_clk),
    .mic_data (mic_data),
    .mic_lrsel(mic_lrsel)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n = q.size();
    s = '0;
    s[0] = (n == 0);
    s[1] = (n == DEPTH);
    s[2] = m_ovf;
    s[3] = m_en;
    s[8 +: FIFO_AW+1] = n[FIFO_AW:0];
    return s;
  endfunction

  function automatic logic [31:0] exp_head();
    return (q.size() > 0) ? 32'(q[0]) : 32'd0;
  endfunction

  function automatic void fifo_ev(bit push, int val, bit pop,
                                  bit clr, bit clro);
    bit set;
    set = push && (q.size() == DEPTH) && !pop;
    if (clr) begin
      q.delete();
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (push && q.size() < DEPTH) q.push_back(val);
    end
    if (set) m_ovf = 1;
    else if (clro) m_ovf = 0;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_en = 0;
    m_ovf = 0;
    m_bits = 0;
    m_ones = 0;
  endfunction

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1;
    write = 1'b1;
    addr = a;
    wr_data = d;
    @(negedge clk);
    cs = 1'b0;
    write = 1'b0;
  endtask

  task automatic ctrl(input logic [31:0] d);
    wr(5'd3, d);
    m_en = d[0];
    if (!d[0]) begin
      m_bits = 0;
      m_ones = 0;
    end
    fifo_ev(0, 0, 0, d[1], d[2]);
  endtask

  task automatic pop();
    wr(5'd2, 32'd0);
    fifo_ev(0, 0, 1, 0, 0);
  endtask

  task automatic check_regs(string tag);
    logic [31:0] v;
    rd(5'd1, v);
    chk({tag, "_status"}, v, exp_status());
    rd(5'd0, v);
    chk({tag, "_head"}, v, exp_head());
  endtask

  task automatic wait_rise(output bit ok);
    ok = 0;
    for (int i = 0; i < 4 * CLK_DIV + 4; i++) begin
      @(negedge clk);
      if (mic_clk) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rise_timeout", {31'd0, mic_clk}, 32'd1);
  endtask

  // One PDM bit; act 1 pops and act 2 writes control 0x3 on the
  // clock edge where the bit is captured.
  task automatic pdm_bit(input bit b, input int act);
    bit ok;
    bit last;
    wait_rise(ok);
    if (!ok) return;
    mic_data = b;
    repeat (CLK_DIV - 1) @(negedge clk);
    chk("mic_clk_high", {31'd0, mic_clk}, 32'd1);
    if (act == 1) begin
      cs = 1'b1; write = 1'b1; addr = 5'd2;
    end else if (act == 2) begin
      cs = 1'b1; write = 1'b1; addr = 5'd3; wr_data = 32'h3;
    end
    @(negedge clk);
    cs = 1'b0;
    write = 1'b0;
    chk("mic_clk_low", {31'd0, mic_clk}, 32'd0);
    m_ones += int'(b);
    m_bits++;
    last = (m_bits == DECIM);
    fifo_ev(last, m_ones, act == 1, act == 2, act == 2);
    if (last) begin
      m_bits = 0;
      m_ones = 0;
    end
    if (act == 2) m_en = 1;
    if (last || act != 0) check_regs("bit");
  endtask

  task automatic window_rand(input int last_act);
    for (int i = 0; i < DECIM; i++)
      pdm_bit(1'($urandom_range(0, 1)), (i == DECIM - 1) ? last_act : 0);
  endtask

  initial begin
    logic [31:0] v;
    bit ok;
    int newest;

    // reset state
    repeat (2) @(negedge clk);
    rd(5'd1, v);
    chk("rst_status", v, 32'h1);
    rd(5'd0, v);
    chk("rst_head", v, 32'h0);
    rd(5'd2, v);
    chk("rst_reg2", v, 32'h0);
    chk("rst_mic_clk", {31'd0, mic_clk}, 32'd0);
    chk("rst_lrsel", {31'd0, mic_lrsel}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // async reset mid-window with data in the FIFO
    ctrl(32'h1);
    window_rand(0);
    for (int i = 0; i < 5; i++) pdm_bit(1'($urandom_range(0, 1)), 0);
    wait_rise(ok);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_mic_clk", {31'd0, mic_clk}, 32'd0);
    rd(5'd1, v);
    chk("arst_status", v, 32'h1);
    rd(5'd0, v);
    chk("arst_head", v, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // all ones -> DECIM, then pop
    ctrl(32'h1);
    rd(5'd3, v);
    chk("reg3_en", v, 32'h1);
    for (int i = 0; i < DECIM; i++) pdm_bit(1'b1, 0);
    rd(5'd0, v);
    chk("ones_head", v, 32'(DECIM));
    pop();
    rd(5'd1, v);
    chk("pop_status", v, 32'h9);

    // alternating -> DECIM/2, all zeros -> 0
    for (int i = 0; i < DECIM; i++) pdm_bit(1'(i % 2), 0);
    rd(5'd0, v);
    chk("alt_head", v, 32'(DECIM / 2));
    pop();
    for (int i = 0; i < DECIM; i++) pdm_bit(1'b0, 0);
    rd(5'd1, v);
    chk("zero_status", v, 32'h0000_0108);
    rd(5'd0, v);
    chk("zero_head", v, 32'h0);
    pop();

    // random windows, popped one by one
    for (int w = 0; w < 3; w++) begin
      window_rand(0);
      pop();
      check_regs("rand_pop");
    end

    // fill past capacity without pops
    for (int w = 0; w < DEPTH + 1; w++) window_rand(0);
    rd(5'd1, v);
    chk("full_status", v, 32'h0000_100E);
    ctrl(32'h5);
    rd(5'd1, v);
    chk("ovf_clr_status", v, 32'h0000_100A);

    // pop on the push edge while full
    window_rand(1);
    rd(5'd1, v);
    chk("full_pushpop", v, 32'h0000_100A);
    newest = q[q.size() - 1];
    ctrl(32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      check_regs("drain");
      if (i == DEPTH - 1) begin
        rd(5'd0, v);
        chk("tail_newest", v, 32'(newest));
      end
      pop();
    end
    check_regs("drained");

    // clear FIFO on a push edge
    ctrl(32'h1);
    window_rand(0);
    window_rand(2);
    rd(5'd1, v);
    chk("clr_on_push", v, 32'h9);

    // disable mid-window, then a fresh full-ones window
    for (int i = 0; i < 9; i++) pdm_bit(1'($urandom_range(0, 1)), 0);
    wait_rise(ok);
    ctrl(32'h0);
    @(negedge clk);
    chk("dis_mic_clk", {31'd0, mic_clk}, 32'd0);
    repeat (3 * DECIM * CLK_DIV) @(negedge clk);
    chk("dis_idle_clk", {31'd0, mic_clk}, 32'd0);
    check_regs("dis_nopush");
    rd(5'd2, v);
    chk("reg2_dis", v, 32'h0);
    mic_data = 1'b1;
    ctrl(32'h1);
    for (int i = 0; i < DECIM; i++) pdm_bit(1'b1, 0);
    rd(5'd0, v);
    chk("reen_head", v, 32'(DECIM));
    rd(5'd1, v);
    chk("reen_status", v, 32'h0000_0108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
